// File: rtl/rank_sched_pkg.sv
// Shared types and constants for the rank scheduler arbiter.
package rank_sched_pkg;
  localparam int COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_REPORT = 2'd2
  } state_t;
endpackage

// File: rtl/rank_sched_top2_tracker.sv
// Tracks the largest and second-largest beat value of a frame plus a saturating beat count.
module top2_tracker
  import rank_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   en,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [DATA_WIDTH-1:0]  max,
  output logic [DATA_WIDTH-1:0]  second,
  output logic [COUNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max    <= '0;
      second <= '0;
      count  <= '0;
    end else if (clear) begin
      max    <= '0;
      second <= '0;
      count  <= '0;
    end else if (en) begin
      // >= so that duplicate values occupy both ranks
      if (din >= max) begin
        second <= max;
        max    <= din;
      end else if (din >= second) begin
        second <= din;
      end
      if (count != {COUNT_WIDTH{1'b1}}) begin
        count <= count + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/rank_sched_arbiter.sv
// Grants one requester per frame and reports its top-two values; RANK_SCHED_ROUND_ROBIN_EN selects round-robin over fixed priority.
// Turnaround is 1 grant cycle + 1 cycle per beat + 1 report cycle; stalls on the granted valid and holds results until res_ready.
module rank_sched_arbiter
  import rank_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DATA_WIDTH-1:0]         res_max,
  output logic [DATA_WIDTH-1:0]         res_second,
  output logic [$clog2(NUM_REQ)-1:0]    res_id,
  output logic [COUNT_WIDTH-1:0]        res_count
);

  localparam int IDW = $clog2(NUM_REQ);

  state_t                state;
  logic [IDW-1:0]        grant;
  logic [IDW-1:0]        next_grant;
  logic                  any_req;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  beat;
  logic                  trk_clear;

  assign any_req = |req_valid;

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == IDW'(i)) begin
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
      end
      req_ready[i] = (state == ST_BUSY) && (grant == IDW'(i));
    end
  end

  assign beat      = (state == ST_BUSY) && sel_valid;
  assign trk_clear = (state == ST_IDLE) && any_req;

`ifdef RANK_SCHED_ROUND_ROBIN_EN
  // rr_ptr holds the first index to search, i.e. last grant + 1
  logic [IDW-1:0] rr_ptr;
  logic [IDW:0]   idx;
  logic           found;

  always_comb begin
    next_grant = '0;
    found      = 1'b0;
    idx        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (idx >= (IDW+1)'(NUM_REQ)) begin
        idx = idx - (IDW+1)'(NUM_REQ);
      end
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found      = 1'b1;
        next_grant = idx[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (trk_clear) begin
      rr_ptr <= (next_grant == IDW'(NUM_REQ-1)) ? '0 : next_grant + IDW'(1);
    end
  end
`else
  always_comb begin
    next_grant = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req_valid[i]) begin
        next_grant = IDW'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      grant <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant <= next_grant;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (beat && sel_last) begin
            state <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (res_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  top2_tracker #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_tracker (
    .clk   (clk),
    .reset (reset),
    .clear (trk_clear),
    .en    (beat),
    .din   (sel_data),
    .max   (res_max),
    .second(res_second),
    .count (res_count)
  );

  assign res_valid = (state == ST_REPORT);
  assign res_id    = grant;

endmodule

// File: tb/tb_rank_sched_arbiter.sv
// Directed bench for rank_sched_arbiter: frame table plus hand-written multi-cycle sequences.
module tb_rank_sched_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;

  logic             clk;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic             res_valid;
  logic             res_ready;
  logic [DW-1:0]    res_max;
  logic [DW-1:0]    res_second;
  logic [1:0]       res_id;
  logic [15:0]      res_count;

  int n_pass  = 0;
  int n_total = 0;

  rank_sched_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_max   (res_max),
    .res_second(res_second),
    .res_id    (res_id),
    .res_count (res_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  typedef struct {
    int              rid;
    int              nb;
    logic [3:0][31:0] d;
    logic [31:0]     emax;
    logic [31:0]     esec;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input int rid, input int nb,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3,
                         input logic [31:0] emax, input logic [31:0] esec);
    vecs[i].rid  = rid;
    vecs[i].nb   = nb;
    vecs[i].d[0] = d0;
    vecs[i].d[1] = d1;
    vecs[i].d[2] = d2;
    vecs[i].d[3] = d3;
    vecs[i].emax = emax;
    vecs[i].esec = esec;
  endtask

  // Streams nb beats from requester rid; returns the number of edges until the last beat lands.
  task automatic run_frame(input int rid, input int nb,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3,
                           output int cyc);
    logic [31:0] dd[4];
    int k;
    logic acc;
    dd[0] = d0; dd[1] = d1; dd[2] = d2; dd[3] = d3;
    k = 0;
    cyc = 0;
    req_valid[rid]           = 1'b1;
    req_data[rid*DW +: DW]   = dd[0];
    req_last[rid]            = (nb == 1);
    while (k < nb && cyc < 64) begin
      @(negedge clk);
      acc = req_ready[rid];
      step();
      cyc++;
      if (acc) begin
        k++;
        if (k < nb) begin
          req_data[rid*DW +: DW] = dd[k];
          req_last[rid]          = (k == nb-1);
        end
      end
    end
    req_valid[rid] = 1'b0;
    req_last[rid]  = 1'b0;
    check("frame_beats_accepted", k, nb);
  endtask

  initial begin
    int cyc;
    int exp_id;
    int got;

    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    res_ready = 1'b1;
    #2;
    check("rst_res_valid",  res_valid,  0);
    check("rst_req_ready",  req_ready,  0);
    check("rst_res_max",    res_max,    0);
    check("rst_res_second", res_second, 0);
    check("rst_res_count",  res_count,  0);
    check("rst_res_id",     res_id,     0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Grant order with every requester continuously sending single-beat frames
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'(10*i + 1);
    req_valid = '1;
    req_last  = '1;
    for (int r = 0; r < 5; r++) begin
`ifdef RANK_SCHED_ROUND_ROBIN_EN
      exp_id = r % NR;
`else
      exp_id = 0;
`endif
      got = 0;
      for (int c = 0; c < 10 && got == 0; c++) begin
        step();
        if (res_valid) got = 1;
      end
      check("grant_result_seen", got, 1);
      check("grant_order_id", res_id, exp_id);
      check("grant_order_max", res_max, 32'(10*exp_id + 1));
    end
    req_valid = '0;
    req_last  = '0;
    step();
    check("grant_drain_idle", res_valid, 0);

    // Table-driven frames, res_ready held high
    set_vec(0, 0, 4, 3,  9, 7, 9,  9, 9);
    set_vec(1, 2, 1, 42, 0, 0, 0,  42, 0);
    set_vec(2, 1, 2, 5,  5, 0, 0,  5, 5);
    set_vec(3, 3, 4, 1,  2, 3, 4,  4, 3);
    set_vec(4, 1, 3, 9,  1, 4, 0,  9, 4);
    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].rid, vecs[v].nb, vecs[v].d[0], vecs[v].d[1],
                vecs[v].d[2], vecs[v].d[3], cyc);
      check("tbl_turnaround", cyc, 1 + vecs[v].nb);
      check("tbl_res_valid", res_valid, 1);
      check("tbl_res_max", res_max, vecs[v].emax);
      check("tbl_res_second", res_second, vecs[v].esec);
      check("tbl_res_count", res_count, vecs[v].nb);
      check("tbl_res_id", res_id, vecs[v].rid);
      step();
      check("tbl_report_one_cycle", res_valid, 0);
    end

    // Result held while the consumer stalls
    res_ready = 1'b0;
    run_frame(0, 2, 7, 2, 0, 0, cyc);
    for (int c = 0; c < 5; c++) begin
      check("stall_res_valid", res_valid, 1);
      check("stall_res_max", res_max, 7);
      check("stall_res_second", res_second, 2);
      check("stall_res_count", res_count, 2);
      check("stall_req_ready", req_ready, 0);
      step();
    end
    check("stall_still_report", res_valid, 1);
    res_ready = 1'b1;
    step();
    check("stall_release_idle", res_valid, 0);

    // Reset in the middle of a frame from requester 1
    req_valid[1]       = 1'b1;
    req_data[1*DW +: DW] = 8;
    step();
    step();
    req_data[1*DW +: DW] = 1;
    step();
    req_data[1*DW +: DW] = 100;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_res_valid",  res_valid,  0);
    check("midrst_req_ready",  req_ready,  0);
    check("midrst_res_max",    res_max,    0);
    check("midrst_res_second", res_second, 0);
    check("midrst_res_count",  res_count,  0);
    check("midrst_res_id",     res_id,     0);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("midrst_no_result", res_valid, 0);
    end
    run_frame(2, 2, 4, 6, 0, 0, cyc);
    check("postrst_res_max", res_max, 6);
    check("postrst_res_second", res_second, 4);
    check("postrst_res_count", res_count, 2);
    check("postrst_res_id", res_id, 2);
    step();

    // Granted requester 3 pauses mid-frame while requester 0 competes
    req_valid[3]         = 1'b1;
    req_data[3*DW +: DW] = 10;
    step();
    step();
    req_data[3*DW +: DW] = 2;
    step();
    req_valid[3]         = 1'b0;
    req_valid[0]         = 1'b1;
    req_data[0*DW +: DW] = 99;
    req_last[0]          = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("gap_req_ready", req_ready, 4'b1000);
      check("gap_res_valid", res_valid, 0);
    end
    req_valid[0]         = 1'b0;
    req_last[0]          = 1'b0;
    req_valid[3]         = 1'b1;
    req_data[3*DW +: DW] = 5;
    req_last[3]          = 1'b1;
    step();
    req_valid[3] = 1'b0;
    req_last[3]  = 1'b0;
    check("gap_res_valid_end", res_valid, 1);
    check("gap_res_max", res_max, 10);
    check("gap_res_second", res_second, 5);
    check("gap_res_count", res_count, 3);
    check("gap_res_id", res_id, 3);
    step();
    check("gap_idle", res_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
